// File: rtl/enc_pkg.sv
// enc_pkg: shared FSM state encoding and pending-vector helper for prio_enc_drain.
package enc_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;
  localparam int ENC_MAX_W = 256;
  function automatic logic popcnt_le1(input logic [ENC_MAX_W-1:0] vec);
    return (vec & (vec - ENC_MAX_W'(1))) == '0;
  endfunction
endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational priority encoder, highest or lowest set bit wins per MSB_FIRST.
module prio_enc_comb #(
  parameter int N         = 8,
  parameter int IDX_W     = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // Later loop iterations override earlier ones, so the scan order sets the winner.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (vec[MSB_FIRST ? i : N-1-i]) idx = IDX_W'(MSB_FIRST ? i : N-1-i);
  end
  assign any = |vec;
endmodule

// File: rtl/prio_enc_drain.sv
// prio_enc_drain: accepts a request vector and drains the index of each set bit, one per beat.
// Optional ENC_ONEHOT_CHK_EN adds onehot_err, pulsed on the first beat of a non-one-hot vector.
module prio_enc_drain
  import enc_pkg::*;
#(
  parameter int N         = 8,
  parameter int IDX_W     = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
`ifdef ENC_ONEHOT_CHK_EN
  ,
  output logic             onehot_err
`endif
);
  state_t           state_q;
  logic [N-1:0]     pend_q;
  logic             zero_q;
  logic [IDX_W-1:0] idx;
  logic             any, emit, last, fire, accept;
  prio_enc_comb #(.N(N), .IDX_W(IDX_W), .MSB_FIRST(MSB_FIRST)) u_enc (
    .vec(pend_q),
    .idx(idx),
    .any(any)
  );
  assign emit      = state_q == ST_EMIT;
  assign last      = !any || popcnt_le1(ENC_MAX_W'(pend_q));
  assign fire      = emit & out_ready;
  assign accept    = !emit & in_valid;
  assign in_ready  = !emit;
  assign out_valid = emit;
  assign out_idx   = emit ? idx : '0;
  assign out_last  = emit & last;
  assign out_zero  = emit & zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      state_q <= ST_EMIT;
      pend_q  <= in_req;
      zero_q  <= in_req == '0;
    end else if (fire) begin
      pend_q  <= pend_q & ~(N'(1) << idx);
      state_q <= last ? ST_IDLE : ST_EMIT;
      zero_q  <= last ? 1'b0 : zero_q;
    end
  end
`ifdef ENC_ONEHOT_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= accept & (in_req == '0 || !popcnt_le1(ENC_MAX_W'(in_req)));
  end
  assign onehot_err = err_q;
`endif
endmodule
